// File: rtl/sdram_port_arbiter.sv
// Two-client round-robin front end for a single sdram_controller.
// One transaction in flight at a time; a watchdog aborts hung accesses with an error ack.
module sdram_port_arbiter #(
  parameter int unsigned HADDR_WIDTH    = 24,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_WIDTH       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   c0_req,
  input  logic                   c0_we,
  input  logic [HADDR_WIDTH-1:0] c0_addr,
  input  logic [15:0]            c0_wdata,
  output logic                   c0_ack,
  output logic                   c0_err,
  output logic [15:0]            c0_rdata,
  input  logic                   c1_req,
  input  logic                   c1_we,
  input  logic [HADDR_WIDTH-1:0] c1_addr,
  input  logic [15:0]            c1_wdata,
  output logic                   c1_ack,
  output logic                   c1_err,
  output logic [15:0]            c1_rdata,
  output logic [HADDR_WIDTH-1:0] ctl_rd_addr,
  output logic [HADDR_WIDTH-1:0] ctl_wr_addr,
  output logic [15:0]            ctl_wr_data,
  output logic                   ctl_rd_enable,
  output logic                   ctl_wr_enable,
  input  logic [15:0]            ctl_rd_data,
  input  logic                   ctl_rd_ready,
  input  logic                   ctl_busy,
  output logic [1:0]             active
);

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    ST_ARB,
    ST_ISSUE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t                 r_state;
  logic                   r_last_grant;
  logic                   r_gnt;
  logic                   r_we;
  logic [HADDR_WIDTH-1:0] r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [TO_WIDTH-1:0]    r_wd;
  logic [1:0]             r_active;
  logic [1:0]             r_ack;
  logic [1:0]             r_err;
  logic [DATA_W-1:0]      r_rdata0;
  logic [DATA_W-1:0]      r_rdata1;

  logic                   w_any_req;
  logic                   w_pick_c1;
  logic                   w_timeout;
  logic [1:0]             w_gnt_oh;

  // Round-robin pick: a lone requester wins; on contention the client not granted last time wins.
  assign w_any_req = c0_req | c1_req;
  assign w_pick_c1 = c1_req & (~c0_req | ~r_last_grant);
  assign w_timeout = (r_wd == TO_WIDTH'(TIMEOUT_CYCLES - 1));
  assign w_gnt_oh  = r_gnt ? 2'b10 : 2'b01;

  // Controller-side drive comes straight from the latched request and the state register.
  assign ctl_rd_addr   = r_addr;
  assign ctl_wr_addr   = r_addr;
  assign ctl_wr_data   = r_wdata;
  assign ctl_rd_enable = (r_state == ST_ISSUE) & ~r_we;
  assign ctl_wr_enable = (r_state == ST_ISSUE) & r_we;

  assign active   = r_active;
  assign c0_ack   = r_ack[0];
  assign c1_ack   = r_ack[1];
  assign c0_err   = r_err[0];
  assign c1_err   = r_err[1];
  assign c0_rdata = r_rdata0;
  assign c1_rdata = r_rdata1;

  // Arbitration, handshake sequencing, watchdog and per-client completion registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_ARB;
      r_last_grant <= 1'b1;
      r_gnt        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wd         <= '0;
      r_active     <= '0;
      r_ack        <= '0;
      r_err        <= '0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_ack <= '0;
      r_err <= '0;
      case (r_state)
        ST_ARB: begin
          if (w_any_req) begin
            r_gnt    <= w_pick_c1;
            r_we     <= w_pick_c1 ? c1_we    : c0_we;
            r_addr   <= w_pick_c1 ? c1_addr  : c0_addr;
            r_wdata  <= w_pick_c1 ? c1_wdata : c0_wdata;
            r_active <= w_pick_c1 ? 2'b10 : 2'b01;
            r_wd     <= '0;
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Enable stays up through refresh stalls until busy is seen or the watchdog fires.
          if (w_timeout) begin
            r_ack   <= w_gnt_oh;
            r_err   <= w_gnt_oh;
            r_state <= ST_DONE;
            if (!r_we) begin
              if (r_gnt) r_rdata1 <= '0;
              else       r_rdata0 <= '0;
            end
          end else begin
            r_wd <= r_wd + TO_WIDTH'(1);
            if (ctl_busy) r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_we ? ~ctl_busy : ctl_rd_ready) begin
            r_ack   <= w_gnt_oh;
            r_state <= ST_DONE;
            if (!r_we) begin
              if (r_gnt) r_rdata1 <= ctl_rd_data;
              else       r_rdata0 <= ctl_rd_data;
            end
          end else if (w_timeout) begin
            r_ack   <= w_gnt_oh;
            r_err   <= w_gnt_oh;
            r_state <= ST_DONE;
            if (!r_we) begin
              if (r_gnt) r_rdata1 <= '0;
              else       r_rdata0 <= '0;
            end
          end else begin
            r_wd <= r_wd + TO_WIDTH'(1);
          end
        end
        ST_DONE: begin
          r_last_grant <= r_gnt;
          r_active     <= 2'b00;
          r_state      <= ST_ARB;
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: behavioural controller model plus a transaction-level
// reference (round-robin winner, memory contents, watchdog outcome) checked every cycle.
module tb_sdram_port_arbiter;

  localparam int unsigned AW  = 24;
  localparam int unsigned DW  = 16;
  localparam int unsigned TMO = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          c0_req, c0_we, c0_ack, c0_err;
  logic [AW-1:0] c0_addr;
  logic [DW-1:0] c0_wdata, c0_rdata;
  logic          c1_req, c1_we, c1_ack, c1_err;
  logic [AW-1:0] c1_addr;
  logic [DW-1:0] c1_wdata, c1_rdata;
  logic [AW-1:0] ctl_rd_addr, ctl_wr_addr;
  logic [DW-1:0] ctl_wr_data, ctl_rd_data;
  logic          ctl_rd_enable, ctl_wr_enable, ctl_rd_ready, ctl_busy;
  logic [1:0]    active;

  sdram_port_arbiter #(.HADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO), .TO_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_ack(c0_ack), .c0_err(c0_err), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_ack(c1_ack), .c1_err(c1_err), .c1_rdata(c1_rdata),
    .ctl_rd_addr(ctl_rd_addr), .ctl_wr_addr(ctl_wr_addr), .ctl_wr_data(ctl_wr_data),
    .ctl_rd_enable(ctl_rd_enable), .ctl_wr_enable(ctl_wr_enable),
    .ctl_rd_data(ctl_rd_data), .ctl_rd_ready(ctl_rd_ready), .ctl_busy(ctl_busy),
    .active(active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_init(input logic [7:0] i);
    if (i == 8'h34) return 16'hBEEF;
    return {i, ~i} ^ 16'h1357;
  endfunction

  // ---------------- controller model ----------------
  int          cm_state, cm_cnt;
  int          cm_accept = 2;   // cycles from enable rising to busy rising
  int          cm_lat    = 4;   // cycles busy stays high
  bit          cm_hang   = 1'b0;
  logic        cm_we;
  logic [7:0]  cm_idx;
  logic [15:0] cm_wdata;
  logic [15:0] cm_mem [256];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cm_state <= 0; cm_cnt <= 0; cm_we <= 1'b0; cm_idx <= '0; cm_wdata <= '0;
      ctl_busy <= 1'b0; ctl_rd_ready <= 1'b0; ctl_rd_data <= '0;
      for (int i = 0; i < 256; i++) cm_mem[i] <= mem_init(8'(i));
    end else begin
      ctl_rd_ready <= 1'b0;
      if (cm_state == 0) begin
        if ((ctl_rd_enable || ctl_wr_enable) && !cm_hang) begin
          if (cm_cnt + 1 >= cm_accept) begin
            ctl_busy <= 1'b1; cm_state <= 1; cm_cnt <= 0;
            cm_we    <= ctl_wr_enable;
            cm_idx   <= ctl_wr_enable ? ctl_wr_addr[7:0] : ctl_rd_addr[7:0];
            cm_wdata <= ctl_wr_data;
          end else cm_cnt <= cm_cnt + 1;
        end else cm_cnt <= 0;
      end else begin
        if (cm_cnt + 1 >= cm_lat) begin
          ctl_busy <= 1'b0; cm_state <= 0; cm_cnt <= 0;
          if (cm_we) cm_mem[cm_idx] <= cm_wdata;
          else begin
            ctl_rd_ready <= 1'b1;
            ctl_rd_data  <= cm_mem[cm_idx];
          end
        end else cm_cnt <= cm_cnt + 1;
      end
    end
  end

  // ---------------- clients and reference ----------------
  logic        cl_pending [2];
  logic        cl_we      [2];
  logic [23:0] cl_addr    [2];
  logic [15:0] cl_wdata   [2];
  logic [15:0] exp_rdata  [2];
  logic [15:0] ref_mem    [256];
  int          remaining  [2];
  int          exp_gnt, exp_last, en_run, last_en_run, n_acks, mode;
  bit          arb_open, expect_err;
  logic [1:0]  req_before;
  int          grant_log [$];

  task automatic reset_model();
    exp_gnt = -1; exp_last = 1; arb_open = 1'b1; expect_err = 1'b0;
    en_run = 0; last_en_run = 0; mode = 0;
    cm_accept = 2; cm_lat = 4; cm_hang = 1'b0;
    grant_log.delete();
    for (int c = 0; c < 2; c++) begin
      cl_pending[c] = 1'b0; cl_we[c] = 1'b0; cl_addr[c] = '0; cl_wdata[c] = '0;
      exp_rdata[c] = '0; remaining[c] = 0;
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(8'(i));
  endtask

  task automatic drive();
    c0_req = cl_pending[0]; c0_we = cl_we[0]; c0_addr = cl_addr[0]; c0_wdata = cl_wdata[0];
    c1_req = cl_pending[1]; c1_we = cl_we[1]; c1_addr = cl_addr[1]; c1_wdata = cl_wdata[1];
  endtask

  task automatic load_txn(input int c, input logic we, input logic [23:0] a, input logic [15:0] d);
    cl_pending[c] = 1'b1; cl_we[c] = we; cl_addr[c] = a; cl_wdata[c] = d;
  endtask

  // Per-cycle comparison of the DUT against the transaction-level expectation.
  task automatic monitor();
    logic [1:0] ackv, oh;
    logic       en;
    int         w, g, o;
    ackv = {c1_ack, c0_ack};
    en   = ctl_rd_enable | ctl_wr_enable;
    if (exp_gnt < 0) begin
      if (arb_open && req_before != 2'b00) begin
        if (req_before == 2'b11) w = 1 - exp_last;
        else                     w = req_before[1] ? 1 : 0;
        check("grant", active, (w == 1) ? 2'b10 : 2'b01);
        exp_gnt = w; grant_log.push_back(w); en_run = 0;
      end else begin
        check("idle_active", active, 2'b00);
        check("idle_ack", ackv, 2'b00);
        check("idle_en", en, 1'b0);
        arb_open = 1'b1;
      end
    end
    if (exp_gnt >= 0) begin
      g  = exp_gnt; o = 1 - g;
      oh = (g == 1) ? 2'b10 : 2'b01;
      if (en) begin
        en_run++;
        check("en_dir", {ctl_wr_enable, ctl_rd_enable}, cl_we[g] ? 2'b10 : 2'b01);
        check("en_addr", ctl_rd_addr, cl_addr[g]);
        check("en_waddr", ctl_wr_addr, cl_addr[g]);
        if (cl_we[g]) check("en_wdata", ctl_wr_data, cl_wdata[g]);
      end else if (en_run > 0) begin
        last_en_run = en_run; en_run = 0;
      end
      check("stray_ack", ackv & ~oh, 2'b00);
      check("active", active, oh);
      if (ackv[g]) begin
        check("err", (g == 1) ? c1_err : c0_err, expect_err);
        check("err_other", (g == 1) ? c0_err : c1_err, 1'b0);
        check("en_cycles", last_en_run, expect_err ? TMO : cm_accept + 1);
        if (!cl_we[g]) exp_rdata[g] = expect_err ? 16'h0000 : ref_mem[cl_addr[g][7:0]];
        else if (!expect_err) ref_mem[cl_addr[g][7:0]] = cl_wdata[g];
        check("rdata", (g == 1) ? c1_rdata : c0_rdata, exp_rdata[g]);
        check("rdata_other", (o == 1) ? c1_rdata : c0_rdata, exp_rdata[o]);
        exp_last = g; exp_gnt = -1; arb_open = 1'b0; cl_pending[g] = 1'b0; n_acks++;
        if (mode == 2) begin
          cm_accept = int'($urandom_range(1, 5));
          cm_lat    = int'($urandom_range(1, 6));
        end
      end
    end
  endtask

  task automatic step();
    drive();
    req_before = {c1_req, c0_req};
    @(posedge clk); #1;
    monitor();
  endtask

  task automatic refill();
    for (int c = 0; c < 2; c++) begin
      if (!cl_pending[c] && remaining[c] > 0 && (mode == 1 || $urandom_range(0, 2) == 0)) begin
        load_txn(c, 1'($urandom_range(0, 1)), 24'($urandom()), 16'($urandom()));
        remaining[c]--;
      end
    end
  endtask

  task automatic run_until_acks(input string tag, input int n, input int limit);
    int target;
    target = n_acks + n;
    for (int i = 0; i < limit && n_acks < target; i++) begin
      refill();
      step();
    end
    check(tag, n_acks, target);
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    n_acks = 0;
    reset_model();
    drive();
    repeat (3) @(posedge clk);
    #1;
    check("rst_active", active, 2'b00);
    check("rst_en", {ctl_wr_enable, ctl_rd_enable}, 2'b00);
    check("rst_ack_err", {c1_ack, c0_ack, c1_err, c0_err}, 4'b0000);
    check("rst_rdata", {c1_rdata, c0_rdata}, 32'h0);
    check("rst_addr", ctl_rd_addr, 24'h0);
    rst = 1'b0;

    // single read, controller returns BEEF
    load_txn(0, 1'b0, 24'h0A1234, 16'h0000);
    run_until_acks("wait_read", 1, 60);
    check("read_beef", c0_rdata, 16'hBEEF);

    // single write from c1, then read it back through c0
    load_txn(1, 1'b1, 24'h000010, 16'h5A5A);
    run_until_acks("wait_write", 1, 60);
    load_txn(0, 1'b0, 24'h000010, 16'h0000);
    run_until_acks("wait_readback", 1, 60);
    check("readback", c0_rdata, 16'h5A5A);

    // refresh collision: busy held off for 12 cycles after the enable rises
    cm_accept = 12;
    load_txn(0, 1'b0, 24'h3300C7, 16'h0000);
    run_until_acks("wait_refresh", 1, 80);
    check("refresh_en_len", last_en_run, 13);
    cm_accept = 2;

    // timeout: controller never answers
    cm_hang = 1'b1; expect_err = 1'b1;
    load_txn(0, 1'b0, 24'h00005B, 16'h0000);
    run_until_acks("wait_timeout", 1, 400);
    check("timeout_rdata", c0_rdata, 16'h0000);
    cm_hang = 1'b0; expect_err = 1'b0;
    load_txn(0, 1'b0, 24'h000034, 16'h0000);
    run_until_acks("wait_after_timeout", 1, 60);

    // contention right after reset: strict alternation starting with c0
    rst = 1'b1; reset_model(); drive();
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    mode = 1; remaining[0] = 2; remaining[1] = 2;
    run_until_acks("wait_contention", 4, 200);
    check("cont_count", grant_log.size(), 4);
    for (int i = 0; i < grant_log.size() && i < 4; i++) check("cont_order", grant_log[i], i % 2);

    // randomized traffic
    mode = 2; remaining[0] = 20; remaining[1] = 20;
    run_until_acks("wait_random", 40, 4000);
    mode = 0; cm_accept = 2; cm_lat = 4;

    // async reset in BUSY: everything clears at once and no ack follows
    for (int i = 0; i < 4; i++) step();
    cm_lat = 20;
    load_txn(0, 1'b0, 24'h00ABCD, 16'h0000);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ctl_rd_enable) seen = 1'b1;
      else if (seen) break;
    end
    step(); step();
    check("pre_rst_active", active, 2'b01);
    rst = 1'b1;
    #1;
    check("arst_active", active, 2'b00);
    check("arst_en", {ctl_wr_enable, ctl_rd_enable}, 2'b00);
    check("arst_ack_err", {c1_ack, c0_ack, c1_err, c0_err}, 4'b0000);
    check("arst_rdata", {c1_rdata, c0_rdata}, 32'h0);
    reset_model(); drive();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("arst_no_ack", {c1_ack, c0_ack}, 2'b00);
    end
    rst = 1'b0;
    load_txn(1, 1'b1, 24'h000077, 16'hC0DE);
    run_until_acks("wait_post_rst", 1, 60);
    check("post_rst_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
    load_txn(1, 1'b0, 24'h000077, 16'h0000);
    run_until_acks("wait_post_rst_rd", 1, 60);
    check("post_rst_rdata", c1_rdata, 16'hC0DE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Two-client front end that shares one sdram_controller instance.
- Round-robin arbitration between client 0 and client 1. The winner's request is converted into the controller's rd_enable/wr_enable handshake, and the ack (plus read data) is returned to the winner.
- Absorbs controller refresh stalls by holding the enable until the controller reports busy.
- A watchdog terminates any hung transaction with an error ack.

Parameters:
- HADDR_WIDTH, 24, host address width (bank+row+col); matches controller.
- TIMEOUT_CYCLES, 255, max cycles allowed in ISSUE+BUSY before abort; must be < 2^TO_WIDTH.
- TO_WIDTH, 8, watchdog counter width.

Ports:
- Port names below use the prefix cN_, with N = 0 and 1 (one set per client).
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- cN_req  in  1  client request; held high with fields stable until cN_ack.
- cN_we  in  1  1 = write, 0 = read.
- cN_addr  in  HADDR_WIDTH  host address.
- cN_wdata  in  16  write data.
- cN_ack  out  1  one-cycle completion pulse.
- cN_err  out  1  high together with cN_ack if the transaction timed out.
- cN_rdata  out  16  read data; valid during cN_ack of a read.
- ctl_rd_addr  out  HADDR_WIDTH  to controller rd_addr.
- ctl_wr_addr  out  HADDR_WIDTH  to controller wr_addr.
- ctl_wr_data  out  16  to controller wr_data.
- ctl_rd_enable  out  1  to controller rd_enable.
- ctl_wr_enable  out  1  to controller wr_enable.
- ctl_rd_data  in  16  from controller rd_data.
- ctl_rd_ready  in  1  from controller rd_ready.
- ctl_busy  in  1  from controller busy.
- active  out  2  one-hot grant {c1,c0}; 00 when no transaction is in flight.

Behaviour:
- Reset (async, rst=1):
  - State = ARB, active = 00, last_grant = 1 (so client 0 wins first).
  - All enables, acks and errs = 0; rdata regs = 0; latched addr/data = 0; watchdog = 0.
- Latched request registers: addr_q, wdata_q, we_q, gnt_q.
  - ctl_rd_addr = ctl_wr_addr = addr_q; ctl_wr_data = wdata_q.
  - ctl_rd_enable = (state==ISSUE) & ~we_q.
  - ctl_wr_enable = (state==ISSUE) & we_q.
- ARB:
  - No req: stay in ARB.
  - One req: grant it.
  - Both req: grant the client not equal to last_grant.
  - On grant: latch that client's fields, set gnt_q, set active, clear watchdog, go to ISSUE the next cycle.
- ISSUE:
  - Enable is held high every cycle until ctl_busy is sampled 1, then go to BUSY; the enable is low from that cycle on.
  - If the controller enters refresh instead of the access, busy stays 0 and the enable stays high until the controller returns to idle and accepts it. No request is lost.
- BUSY, read: ctl_rd_ready sampled 1 -> capture ctl_rd_data into the granted client's rdata reg, go to DONE.
- BUSY, write: ctl_busy sampled 0 -> go to DONE.
- DONE:
  - cN_ack=1 for the granted client for exactly one cycle.
  - last_grant <= gnt_q; active <= 00; go to ARB.
  - A req still high in the next ARB cycle is a new transaction.
- Watchdog:
  - Increments every cycle in ISSUE or BUSY.
  - When it reaches TIMEOUT_CYCLES: drop the enable, go to DONE with cN_err=1.
  - Timed-out read returns rdata = 16'h0000.
- Minimum latency, req to ack:
  - Read: ARB 1 + ISSUE (busy arrives 2 cycles after enable) + controller read path + DONE 1, about 11 cycles.
  - Write: about 9 cycles.
- Ack is never issued to a non-granted client. At most one transaction is in flight. The non-granted client's rdata is never modified.
- Reset mid-transaction aborts silently (no ack); the controller must be reset in the same window.

Test Plan:
- Single read: c0 read addr 24'h0A1234; controller model returns 16'hBEEF.
  - Required: ctl_rd_enable held until busy; c0_ack pulses once with c0_rdata=16'hBEEF, c0_err=0; active=01 during the transaction.
- Single write: c1 write addr 24'h000010, data 16'h5A5A.
  - Required: ctl_wr_enable=1 with ctl_wr_addr=24'h000010 and ctl_wr_data=16'h5A5A until busy=1; c1_ack one cycle after busy falls.
- Contention, both clients requesting continuously for 4 transactions:
  - Required: grants alternate c0,c1,c0,c1 starting with c0 after reset; exactly 4 acks.
- Refresh collision: controller model keeps busy=0 for 12 cycles after the enable is raised.
  - Required: enable stays high all 12 cycles; the access then completes with correct data/ack and err=0.
- Timeout: controller model never raises busy.
  - Required: after 255 cycles in ISSUE, enable drops, c0_ack=1 and c0_err=1, c0_rdata=0, arbiter returns to ARB.
- Async reset asserted in BUSY:
  - Required: all outputs 0 immediately, no ack; after release, a new c1-only request is granted.
